// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state type, tap indices and width helper for the 3x3 convolution engine
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DRAIN
  } conv_state_t;

  // Window rows (oldest line first) and columns (oldest pixel first)
  localparam int TAP_TOP    = 0;
  localparam int TAP_MID    = 1;
  localparam int TAP_BOT    = 2;
  localparam int TAP_LEFT   = 0;
  localparam int TAP_CENTRE = 1;
  localparam int TAP_RIGHT  = 2;

  function automatic int acc_width_default(input int data_width, input int coef_width);
    return data_width + coef_width + 4;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// rtl/conv_line_buffer.sv - two row delays over the pushed pixel stream; contents are never reset
module conv_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] tap_cur,
  output logic [DATA_WIDTH-1:0] tap_row1,
  output logic [DATA_WIDTH-1:0] tap_row2
);

  logic [DATA_WIDTH-1:0] sr [2*IMG_WIDTH];

  always_ff @(posedge clk) begin
    if (push) begin
      sr[0] <= data;
      for (int i = 2*IMG_WIDTH-1; i > 0; i--) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign tap_cur  = data;
  assign tap_row1 = sr[IMG_WIDTH-1];
  assign tap_row2 = sr[2*IMG_WIDTH-1];

endmodule

// File: rtl/conv3x3_stream_engine.sv
// rtl/conv3x3_stream_engine.sv - streaming zero-padded 3x3 convolution with internal flush and backpressure
// CONV_SATURATE_EN adds a shift/clamp output stage (latency 4 instead of 3).
module conv3x3_stream_engine
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 8,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int ACC_WIDTH  = acc_width_default(DATA_WIDTH, COEF_WIDTH),
  parameter int OUT_SHIFT  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [9*COEF_WIDTH-1:0] flat_weights,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_WIDTH-1:0]    out_pixel,
  output logic                    out_eol,
  output logic                    out_last
);

  localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int CNT_W = $clog2(NPIX + IMG_WIDTH + 2);
  localparam int COL_W = $clog2(IMG_WIDTH + 1);
  localparam int ROW_W = $clog2(IMG_HEIGHT + 1);
  localparam int FL_W  = $clog2(IMG_WIDTH + 2);

  if (IMG_WIDTH < 2 || IMG_HEIGHT < 2 || OUT_SHIFT < 0) begin : g_bad_params
    $error("conv3x3_stream_engine: image must be at least 2x2 and OUT_SHIFT non-negative");
  end

  conv_state_t             state;
  logic                    accept_en;
  logic                    stall;
  logic                    accept;
  logic                    flush_tick;
  logic                    push;
  logic                    complete;
  logic [DATA_WIDTH-1:0]   push_data;
  logic [CNT_W-1:0]        in_cnt;
  logic [CNT_W-1:0]        push_cnt;
  logic [COL_W-1:0]        ccol;
  logic [ROW_W-1:0]        crow;
  logic [FL_W-1:0]         fl_cnt;
  logic [9*COEF_WIDTH-1:0] weights;

  assign stall      = out_valid && !out_ready;
  assign in_ready   = accept_en && !stall;
  assign accept     = in_valid && in_ready;
  assign flush_tick = (state == FLUSH) && !stall;
  assign push       = accept || flush_tick;
  assign push_data  = accept ? in_data : '0;
  // Push index W+1 is the first one whose window is centred on pixel (0,0)
  assign complete   = push && (push_cnt >= CNT_W'(IMG_WIDTH + 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      accept_en <= 1'b0;
      in_cnt    <= '0;
      push_cnt  <= '0;
      ccol      <= '0;
      crow      <= '0;
      fl_cnt    <= '0;
      weights   <= '0;
    end else begin
      if (push) push_cnt <= push_cnt + 1'b1;
      if (complete) begin
        if (ccol == COL_W'(IMG_WIDTH - 1)) begin
          ccol <= '0;
          crow <= crow + 1'b1;
        end else begin
          ccol <= ccol + 1'b1;
        end
      end
      case (state)
        IDLE: begin
          accept_en <= 1'b1;
          if (accept) begin
            weights <= flat_weights;
            in_cnt  <= CNT_W'(1);
            state   <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            in_cnt <= in_cnt + 1'b1;
            if (in_cnt == CNT_W'(NPIX - 1)) begin
              accept_en <= 1'b0;
              state     <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (flush_tick) begin
            fl_cnt <= fl_cnt + 1'b1;
            if (fl_cnt == FL_W'(IMG_WIDTH)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_valid && out_ready && out_last) begin
            state     <= IDLE;
            accept_en <= 1'b1;
            in_cnt    <= '0;
            push_cnt  <= '0;
            ccol      <= '0;
            crow      <= '0;
            fl_cnt    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [DATA_WIDTH-1:0] tap  [3];
  logic [DATA_WIDTH-1:0] hist [3][2];
  logic [DATA_WIDTH-1:0] win  [3][3];
  logic [2:0]            row_ok;
  logic [2:0]            col_ok;

  conv_line_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .IMG_WIDTH (IMG_WIDTH)
  ) u_line_buffer (
    .clk     (clk),
    .push    (push),
    .data    (push_data),
    .tap_cur (tap[TAP_BOT]),
    .tap_row1(tap[TAP_MID]),
    .tap_row2(tap[TAP_TOP])
  );

  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < 3; i++) begin
        hist[i][0] <= hist[i][1];
        hist[i][1] <= tap[i];
      end
    end
  end

  // Borders are handled by masking taps, so stale line-buffer data never reaches the sum
  always_comb begin
    row_ok = 3'b111;
    col_ok = 3'b111;
    if (crow == '0)                     row_ok[TAP_TOP]   = 1'b0;
    if (crow == ROW_W'(IMG_HEIGHT - 1)) row_ok[TAP_BOT]   = 1'b0;
    if (ccol == '0)                     col_ok[TAP_LEFT]  = 1'b0;
    if (ccol == COL_W'(IMG_WIDTH - 1))  col_ok[TAP_RIGHT] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      win[i][TAP_LEFT]   = hist[i][0];
      win[i][TAP_CENTRE] = hist[i][1];
      win[i][TAP_RIGHT]  = tap[i];
    end
  end

  function automatic logic signed [ACC_WIDTH-1:0] mul_tap(input logic [DATA_WIDTH-1:0] p,
                                                          input logic [COEF_WIDTH-1:0] k);
    logic signed [ACC_WIDTH-1:0] pe;
    logic signed [ACC_WIDTH-1:0] ke;
    pe = $signed({{(ACC_WIDTH-DATA_WIDTH){1'b0}}, p});
    ke = $signed({{(ACC_WIDTH-COEF_WIDTH){k[COEF_WIDTH-1]}}, k});
    return pe * ke;
  endfunction

  logic signed [ACC_WIDTH-1:0] prod_next [3][3];
  logic signed [ACC_WIDTH-1:0] prod      [3][3];
  logic signed [ACC_WIDTH-1:0] rsum      [3];
  logic                        v1, v2, eol1, eol2, last1, last2;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        prod_next[i][j] = '0;
        if (row_ok[i] && col_ok[j])
          prod_next[i][j] = mul_tap(win[i][j], weights[(3*i+j)*COEF_WIDTH +: COEF_WIDTH]);
      end
    end
  end

`ifdef CONV_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] PIX_MAX = ACC_WIDTH'((1 << DATA_WIDTH) - 1);

  logic signed [ACC_WIDTH-1:0] sum_q;
  logic                        v3, eol3, last3;

  function automatic logic [ACC_WIDTH-1:0] clamp_pixel(input logic signed [ACC_WIDTH-1:0] s);
    logic signed [ACC_WIDTH-1:0] sh;
    sh = s >>> OUT_SHIFT;
    if (sh < 0)       return '0;
    if (sh > PIX_MAX) return PIX_MAX;
    return sh;
  endfunction
`endif

  // A stall freezes every stage together, so valid bits simply travel with their data
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      eol1      <= 1'b0;
      eol2      <= 1'b0;
      last1     <= 1'b0;
      last2     <= 1'b0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_eol   <= 1'b0;
      out_last  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        rsum[i] <= '0;
        for (int j = 0; j < 3; j++) prod[i][j] <= '0;
      end
`ifdef CONV_SATURATE_EN
      v3    <= 1'b0;
      eol3  <= 1'b0;
      last3 <= 1'b0;
      sum_q <= '0;
`endif
    end else if (!stall) begin
      v1    <= complete;
      eol1  <= (ccol == COL_W'(IMG_WIDTH - 1));
      last1 <= (ccol == COL_W'(IMG_WIDTH - 1)) && (crow == ROW_W'(IMG_HEIGHT - 1));
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) prod[i][j] <= prod_next[i][j];
        rsum[i] <= prod[i][0] + prod[i][1] + prod[i][2];
      end
      v2    <= v1;
      eol2  <= eol1;
      last2 <= last1;
`ifdef CONV_SATURATE_EN
      v3        <= v2;
      eol3      <= eol2;
      last3     <= last2;
      sum_q     <= rsum[0] + rsum[1] + rsum[2];
      out_valid <= v3;
      out_eol   <= eol3;
      out_last  <= last3;
      out_pixel <= clamp_pixel(sum_q);
`else
      out_valid <= v2;
      out_eol   <= eol2;
      out_last  <= last2;
      out_pixel <= rsum[0] + rsum[1] + rsum[2];
`endif
    end
  end

endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// tb/tb_conv3x3_stream_engine.sv - randomized self-checking bench against a direct convolution model
module tb_conv3x3_stream_engine;

  localparam int DW    = 8;
  localparam int CW    = 8;
  localparam int W     = 5;
  localparam int H     = 4;
  localparam int AW    = 20;
  localparam int SHIFT = 0;
  localparam int NPIX  = W * H;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic [9*CW-1:0] flat_weights;
  logic           out_valid;
  logic           out_ready;
  logic [AW-1:0]  out_pixel;
  logic           out_eol;
  logic           out_last;

  int             n_vec = 0;
  int             n_err = 0;
  int             img [NPIX];
  logic [AW-1:0]  exp_pix  [NPIX];
  logic           exp_eol  [NPIX];
  logic           exp_last [NPIX];

  always #5 clk = ~clk;

  conv3x3_stream_engine #(
    .DATA_WIDTH(DW),
    .COEF_WIDTH(CW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .ACC_WIDTH (AW),
    .OUT_SHIFT (SHIFT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .flat_weights(flat_weights),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pixel   (out_pixel),
    .out_eol     (out_eol),
    .out_last    (out_last)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int coef_of(input logic [9*CW-1:0] k, input int i, input int j);
    logic signed [CW-1:0] v;
    v = k[(3*i+j)*CW +: CW];
    return int'(v);
  endfunction

  function automatic int pix_of(input int r, input int c);
    if (r < 0 || r >= H || c < 0 || c >= W) return 0;
    return img[r*W + c];
  endfunction

  function automatic logic [9*CW-1:0] fill_kernel(input int v);
    logic [9*CW-1:0] k;
    for (int t = 0; t < 9; t++) k[t*CW +: CW] = CW'(v);
    return k;
  endfunction

  function automatic logic [9*CW-1:0] ident_kernel();
    logic [9*CW-1:0] k;
    k = '0;
    k[4*CW +: CW] = CW'(1);
    return k;
  endfunction

  task automatic build_expect(input logic [9*CW-1:0] k);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int s;
        s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s += coef_of(k, i, j) * pix_of(r + i - 1, c + j - 1);
`ifdef CONV_SATURATE_EN
        s = s >>> SHIFT;
        if (s < 0) s = 0;
        else if (s > (1 << DW) - 1) s = (1 << DW) - 1;
`endif
        exp_pix[r*W + c]  = AW'(s);
        exp_eol[r*W + c]  = (c == W - 1);
        exp_last[r*W + c] = (r == H - 1) && (c == W - 1);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #4;
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_pixel", out_pixel, 0);
    check_eq("rst_out_eol", out_eol, 0);
    check_eq("rst_out_last", out_last, 0);
    @(negedge clk);
    rst = 1'b0;
    #4;
    check_eq("rst_hold_ready", in_ready, 0);
    @(negedge clk);
    #4;
    check_eq("post_rst_ready", in_ready, 1);
  endtask

  // rmode: 0 = always ready, 1 = alternate, 2 = random
  task automatic run_frame(input int vprob, input int rmode, input int switch_at,
                           input logic [9*CW-1:0] k_after);
    int            sent;
    int            got;
    int            cyc;
    bit            took;
    bit            prev_stall;
    logic [AW-1:0] held;
    sent = 0;
    got = 0;
    cyc = 0;
    took = 1'b0;
    prev_stall = 1'b0;
    held = '0;
    build_expect(flat_weights);
    in_valid = 1'b0;
    while (got < NPIX && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (switch_at >= 0 && sent >= switch_at) flat_weights = k_after;
      if (!in_valid || took) begin
        in_valid = (sent < NPIX) && (int'($urandom_range(99)) < vprob);
        in_data  = (sent < NPIX) ? DW'(img[sent]) : '0;
      end
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = (int'($urandom_range(99)) < 65);
      endcase
      #4;
      if (prev_stall) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_pix", out_pixel, held);
      end
      if (sent == NPIX) check_eq("flush_ready", in_ready, 0);
      took = in_valid && in_ready;
      if (took) sent++;
      prev_stall = out_valid && !out_ready;
      if (prev_stall) begin
        check_eq("stall_ready", in_ready, 0);
        held = out_pixel;
      end
      if (out_valid && out_ready) begin
        check_eq("pix", out_pixel, exp_pix[got]);
        check_eq("eol", out_eol, exp_eol[got]);
        check_eq("last", out_last, exp_last[got]);
        got++;
      end
    end
    check_eq("out_count", got, NPIX);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b0;
    #4;
    check_eq("drained", out_valid, 0);
    check_eq("idle_ready", in_ready, 1);
  endtask

  task automatic run_partial(input int n);
    int sent;
    int cyc;
    sent = 0;
    cyc = 0;
    while (sent < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      in_valid = 1'b1;
      in_data = DW'(img[sent]);
      out_ready = 1'b1;
      #4;
      if (in_valid && in_ready) sent++;
    end
    check_eq("partial_accepts", sent, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    flat_weights = '0;
    do_reset();

    for (int i = 0; i < NPIX; i++) img[i] = i;
    flat_weights = ident_kernel();
    run_frame(100, 0, -1, '0);

    for (int i = 0; i < NPIX; i++) img[i] = 255;
    flat_weights = fill_kernel(1);
    run_frame(100, 0, -1, '0);

    out_ready = 1'b0;
    run_frame(60, 1, -1, '0);

    flat_weights = fill_kernel(-128);
    run_frame(100, 0, -1, '0);

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(255));
      for (int t = 0; t < 9; t++) flat_weights[t*CW +: CW] = CW'($urandom);
      run_frame(70, 2, -1, '0);
    end

    for (int i = 0; i < NPIX; i++) img[i] = i;
    flat_weights = ident_kernel();
    run_partial(7);
    do_reset();
    run_frame(100, 0, -1, '0);

    flat_weights = ident_kernel();
    run_frame(80, 2, 8, fill_kernel(1));
    run_frame(100, 0, -1, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
